// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-FF synchroniser, false-start rejection, parity/stop checking,
// ready/valid holding register with parity, framing and overrun error reporting.
module uart_rx_cfg #(
  parameter int CLKS_PER_BAUD = 1250,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BAUD);
  localparam logic [CW-1:0] MID   = CW'(CLKS_PER_BAUD / 2 - 1);
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BAUD - 1);
  localparam logic [3:0]    NDATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    NSTOP = 4'(STOP_BITS - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  logic                 rx_meta;
  logic                 rxs;
  logic [1:0]           settle;
  logic                 armed;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 frm_bad;
  logic                 commit;
  logic                 par_xor;

  assign busy    = (state != IDLE);
  assign par_xor = (^shreg) ^ rxs;

  // armed blocks a frame already in flight at reset release until the line is seen idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      settle  <= 2'b00;
      armed   <= 1'b0;
    end else begin
      rx_meta <= rx_serial;
      rxs     <= rx_meta;
      settle  <= {settle[0], 1'b1};
      if (settle[1] && rxs)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
      frm_bad <= 1'b0;
      commit  <= 1'b0;
    end else begin
      commit <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (armed && !rxs)
            state <= START;
        end
        START: begin
          if (cnt == MID) begin
            cnt     <= '0;
            bit_cnt <= '0;
            par_bad <= 1'b0;
            frm_bad <= 1'b0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            if (bit_cnt == NDATA) begin
              bit_cnt <= '0;
              state   <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            par_bad <= (PARITY_MODE == 2) ? ~par_xor : par_xor;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (!rxs)
              frm_bad <= 1'b1;
            if (bit_cnt == NSTOP) begin
              commit <= 1'b1;
              state  <= (!rxs || frm_bad) ? WAIT_IDLE : IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rxs)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // a completed frame is dropped rather than overwriting a word the consumer has not taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (commit) begin
        if (!rx_valid || rx_ready) begin
          rx_valid    <= 1'b1;
          rx_data     <= shreg;
          parity_err  <= (PARITY_MODE != 0) && par_bad;
          framing_err <= frm_bad;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid    <= 1'b0;
        parity_err  <= 1'b0;
        framing_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench: instance 0 is 8N1, instance 1 is 8E1; expected words queued at send time.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ser, rdy, vld, perr, ferr, ovr, busy;
  logic [7:0] d0, d1;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_n (
    .clk(clk), .rst(rst), .rx_serial(ser[0]), .rx_ready(rdy[0]), .rx_valid(vld[0]),
    .rx_data(d0), .parity_err(perr[0]), .framing_err(ferr[0]), .overrun_err(ovr[0]),
    .busy(busy[0])
  );

  uart_rx_cfg #(.CLKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_e (
    .clk(clk), .rst(rst), .rx_serial(ser[1]), .rx_ready(rdy[1]), .rx_valid(vld[1]),
    .rx_data(d1), .parity_err(perr[1]), .framing_err(ferr[1]), .overrun_err(ovr[1]),
    .busy(busy[1])
  );

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;
  int   ovr_cnt0 = 0;
  int   ovr_cnt1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input int i, input logic [7:0] d, input logic p, input logic f);
    exp_t e;
    e.d = d;
    e.p = p;
    e.f = f;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // monitor: every accepted word is popped from its scoreboard and compared
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ovr[0]) ovr_cnt0++;
      if (ovr[1]) ovr_cnt1++;
      if (vld[0] && rdy[0]) begin
        if (q0.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected word inst0: got %0h expected none", d0);
        end else begin
          e = q0.pop_front();
          check("inst0 data", 32'(d0), 32'(e.d));
          check("inst0 parity_err", 32'(perr[0]), 32'(e.p));
          check("inst0 framing_err", 32'(ferr[0]), 32'(e.f));
        end
      end
      if (vld[1] && rdy[1]) begin
        if (q1.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected word inst1: got %0h expected none", d1);
        end else begin
          e = q1.pop_front();
          check("inst1 data", 32'(d1), 32'(e.d));
          check("inst1 parity_err", 32'(perr[1]), 32'(e.p));
          check("inst1 framing_err", 32'(ferr[1]), 32'(e.f));
        end
      end
    end
  end

  task automatic bit_time(input int i, input logic v);
    ser[i] = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // par < 0: no parity bit; nlow > 0: stop bit held low for nlow bit-times
  task automatic send(input int i, input logic [7:0] d, input int par, input int nlow);
    bit_time(i, 1'b0);
    for (int b = 0; b < 8; b++) bit_time(i, d[b]);
    if (par >= 0) bit_time(i, par[0]);
    if (nlow > 0) begin
      for (int k = 0; k < nlow; k++) bit_time(i, 1'b0);
    end else begin
      bit_time(i, 1'b1);
    end
  endtask

  task automatic wait_drain(input int i, input string name);
    int n;
    n = 0;
    while (((i == 0) ? q0.size() : q1.size()) != 0 && n < 4 * CPB) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 32'((i == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    ser = 2'b11;
    rdy = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("reset rx_valid", 32'(vld), 32'd0);
    check("reset rx_data0", 32'(d0), 32'd0);
    check("reset rx_data1", 32'(d1), 32'd0);
    check("reset parity_err", 32'(perr), 32'd0);
    check("reset framing_err", 32'(ferr), 32'd0);
    check("reset overrun_err", 32'(ovr), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    expect_word(0, 8'hA5, 1'b0, 1'b0);
    send(0, 8'hA5, -1, 0);
    wait_drain(0, "8N1 A5 delivered");
    check("8N1 no overrun", 32'(ovr_cnt0), 32'd0);

    // 0x3C has four ones: even parity bit is 0
    expect_word(1, 8'h3C, 1'b0, 1'b0);
    send(1, 8'h3C, 0, 0);
    wait_drain(1, "even parity good delivered");
    expect_word(1, 8'h3C, 1'b1, 1'b0);
    send(1, 8'h3C, 1, 0);
    wait_drain(1, "even parity bad delivered");

    expect_word(0, 8'h55, 1'b0, 1'b1);
    send(0, 8'h55, -1, 2);
    wait_drain(0, "framing 55 delivered");
    check("busy while line low", 32'(busy[0]), 32'd1);
    ser[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("busy after line high", 32'(busy[0]), 32'd0);
    expect_word(0, 8'h0F, 1'b0, 1'b0);
    send(0, 8'h0F, -1, 0);
    wait_drain(0, "post-framing 0F delivered");

    rdy[0] = 1'b0;
    ovr_cnt0 = 0;
    expect_word(0, 8'h11, 1'b0, 1'b0);
    send(0, 8'h11, -1, 0);
    send(0, 8'h22, -1, 0);
    bit_time(0, 1'b1);
    check("overrun held valid", 32'(vld[0]), 32'd1);
    check("overrun held data", 32'(d0), 32'h11);
    check("overrun pulse count", 32'(ovr_cnt0), 32'd1);
    rdy[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("overrun valid dropped", 32'(vld[0]), 32'd0);
    check("overrun scoreboard empty", 32'(q0.size()), 32'd0);

    ser[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("glitch enters start", 32'(busy[0]), 32'd1);
    @(posedge clk);
    #1;
    ser[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("glitch busy cleared", 32'(busy[0]), 32'd0);
    check("glitch no valid", 32'(vld[0]), 32'd0);

    // frame 0xF0: reset lands at bit 4, after which the line stays high
    for (int k = 0; k < 5; k++) bit_time(0, 1'b0);
    ser[0] = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midframe reset valid", 32'(vld[0]), 32'd0);
    check("midframe reset data", 32'(d0), 32'd0);
    check("midframe reset busy", 32'(busy[0]), 32'd0);
    check("midframe reset flags", 32'({perr[0], ferr[0], ovr[0]}), 32'd0);
    rst = 1'b0;
    repeat (6 * CPB) @(posedge clk);
    #1;
    check("midframe no spurious valid", 32'(vld[0]), 32'd0);
    check("final scoreboard0 empty", 32'(q0.size()), 32'd0);
    check("final scoreboard1 empty", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
